vga_fb_writer: RTL and testbench



---
 rtl/vga_fb_writer.sv | 157 +++++++++++++++
 tb/tb_vga_fb_writer.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/vga_fb_writer.sv
// vga_fb_writer: 6502 bus register window driving a 160x120x3 framebuffer write port, with a clear/fill engine.
// Latency: bus action lands 3 CLK edges after the first edge that samples CE low; FB_WE/DOUT registered.
// Backpressure: none; the fill engine writes one pixel per cycle and bus writes are dropped while BUSY.
// Optional feature: define VGA_FB_WRITER_AUTOINC_EN to advance X/Y after every PIXEL write.
module vga_fb_writer #(
  parameter int FB_W   = 160,
  parameter int FB_H   = 120,
  parameter int ADDR_W = 15
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [7:0]        DATA,
  input  logic [1:0]        ADDR,
  input  logic              CE,
  input  logic              RW,
  output logic [7:0]        DOUT,
  output logic              FB_WE,
  output logic [ADDR_W-1:0] FB_ADDR,
  output logic [2:0]        FB_DATA,
  output logic              BUSY
);

  localparam logic IDLE = 1'b0;
  localparam logic FILL = 1'b1;

  localparam logic [7:0]        X_MAX     = 8'(FB_W - 1);
  localparam logic [7:0]        Y_MAX     = 8'(FB_H - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_W * FB_H - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

  // CE synchroniser chain plus one extra stage for falling-edge detection
  logic ce_s1_q, ce_s2_q, ce_s3_q;
  logic stb_q;

  logic              state_q, state_d;
  logic [7:0]        x_q, x_d;
  logic [7:0]        y_q, y_d;
  logic [2:0]        col_q, col_d;
  logic [7:0]        dout_q, dout_d;
  logic              fb_we_q, fb_we_d;
  logic [ADDR_W-1:0] fb_addr_q, fb_addr_d;
  logic [2:0]        fb_data_q, fb_data_d;

  logic [ADDR_W-1:0] y_ext, x_ext, pix_addr;

  // Y*160 + X built from shifts: 160 = 128 + 32
  assign y_ext    = ADDR_W'(y_q);
  assign x_ext    = ADDR_W'(x_q);
  assign pix_addr = (y_ext << 7) + (y_ext << 5) + x_ext;

  // Synchronise CE and register a one-cycle strobe on its synchronised falling edge
  always_ff @(posedge CLK) begin
    if (RST) begin
      ce_s1_q <= 1'b1;
      ce_s2_q <= 1'b1;
      ce_s3_q <= 1'b1;
      stb_q   <= 1'b0;
    end else begin
      ce_s1_q <= CE;
      ce_s2_q <= ce_s1_q;
      ce_s3_q <= ce_s2_q;
      stb_q   <= ce_s3_q & ~ce_s2_q;
    end
  end

  // Next-state: fill sequencing, register decode on the strobe cycle, read mux
  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    col_d     = col_q;
    dout_d    = dout_q;
    fb_we_d   = 1'b0;
    fb_addr_d = fb_addr_q;
    fb_data_d = fb_data_q;

    if (state_q == FILL) begin
      if (fb_addr_q == LAST_ADDR) begin
        state_d = IDLE;
      end else begin
        fb_we_d   = 1'b1;
        fb_addr_d = fb_addr_q + ADDR_ONE;
      end
    end

    if (stb_q) begin
      if (RW) begin
        // Reads are side-effect free and allowed in either state
        case (ADDR)
          2'd0:    dout_d = x_q;
          2'd1:    dout_d = y_q;
          2'd2:    dout_d = {5'b0, col_q};
          default: dout_d = {(state_q == FILL), 7'b0};
        endcase
      end else if (state_q == IDLE) begin
        case (ADDR)
          2'd0: x_d = (DATA > X_MAX) ? X_MAX : DATA;
          2'd1: y_d = (DATA > Y_MAX) ? Y_MAX : DATA;
          2'd2: begin
            fb_we_d   = 1'b1;
            fb_addr_d = pix_addr;
            fb_data_d = DATA[2:0];
            col_d     = DATA[2:0];
`ifdef VGA_FB_WRITER_AUTOINC_EN
            if (x_q == X_MAX) begin
              x_d = 8'd0;
              y_d = (y_q == Y_MAX) ? 8'd0 : y_q + 8'd1;
            end else begin
              x_d = x_q + 8'd1;
            end
`else
`endif
          end
          default: begin
            if (DATA[7]) begin
              // First fill write goes out in the same cycle BUSY rises
              state_d   = FILL;
              fb_we_d   = 1'b1;
              fb_addr_d = '0;
              fb_data_d = DATA[2:0];
            end
          end
        endcase
      end
    end
  end

  // Register state, bus registers and the framebuffer write port
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      x_q       <= 8'd0;
      y_q       <= 8'd0;
      col_q     <= 3'd0;
      dout_q    <= 8'd0;
      fb_we_q   <= 1'b0;
      fb_addr_q <= '0;
      fb_data_q <= 3'd0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      col_q     <= col_d;
      dout_q    <= dout_d;
      fb_we_q   <= fb_we_d;
      fb_addr_q <= fb_addr_d;
      fb_data_q <= fb_data_d;
    end
  end

  assign DOUT    = dout_q;
  assign FB_WE   = fb_we_q;
  assign FB_ADDR = fb_addr_q;
  assign FB_DATA = fb_data_q;
  assign BUSY    = (state_q == FILL);

endmodule

// File: tb/tb_vga_fb_writer.sv
// Self-checking bench for vga_fb_writer: bus-level stimulus, reference model, framebuffer write scoreboard.
module tb_vga_fb_writer;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [7:0]  DATA = 8'd0;
  logic [1:0]  ADDR = 2'd0;
  logic        CE = 1'b1;
  logic        RW = 1'b1;
  logic [7:0]  DOUT;
  logic        FB_WE;
  logic [14:0] FB_ADDR;
  logic [2:0]  FB_DATA;
  logic        BUSY;

  vga_fb_writer dut (
    .CLK(CLK), .RST(RST), .DATA(DATA), .ADDR(ADDR), .CE(CE), .RW(RW),
    .DOUT(DOUT), .FB_WE(FB_WE), .FB_ADDR(FB_ADDR), .FB_DATA(FB_DATA), .BUSY(BUSY)
  );

  always #10 CLK = ~CLK;

  typedef struct { int addr; int data; } fbw_t;
  fbw_t exp_q[$];

  int total = 0;
  int bad   = 0;

  // Reference model state
  int  mx = 0, my = 0, mcol = 0;
  bit  mbusy = 0;

  // Free-running counters used to prove the fill is back-to-back
  int we_busy_cnt = 0;
  int busy_cnt    = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Monitor: every FB_WE cycle must match the head of the expected queue
  always @(negedge CLK) begin
    if (FB_WE) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL fb_write: unexpected write addr=%0d data=%0d, expected no write", FB_ADDR, FB_DATA);
      end else begin
        fbw_t e;
        e = exp_q.pop_front();
        if (int'(FB_ADDR) != e.addr || int'(FB_DATA) != e.data) begin
          bad++;
          $display("FAIL fb_write: got addr=%0d data=%0d expected addr=%0d data=%0d",
                   FB_ADDR, FB_DATA, e.addr, e.data);
        end
      end
    end
  end

  always @(negedge CLK) begin
    if (BUSY) busy_cnt++;
    if (BUSY && FB_WE) we_busy_cnt++;
  end

  task automatic bus(input bit rw, input logic [1:0] a, input logic [7:0] d,
                     input int hold, output logic [7:0] rd);
    @(negedge CLK);
    RW = rw; ADDR = a; DATA = d; CE = 1'b0;
    repeat (hold) @(negedge CLK);
    rd = DOUT;
    CE = 1'b1;
    repeat (4) @(negedge CLK);
  endtask

  // Model of a register write, then the bus cycle itself
  task automatic wr(input int a, input int d, input int hold);
    logic [7:0] dummy;
    if (!mbusy) begin
      case (a)
        0: mx = (d > 159) ? 159 : d;
        1: my = (d > 119) ? 119 : d;
        2: begin
          exp_q.push_back('{addr: my * 160 + mx, data: d % 8});
          mcol = d % 8;
`ifdef VGA_FB_WRITER_AUTOINC_EN
          mx = mx + 1;
          if (mx == 160) begin
            mx = 0;
            my = (my == 119) ? 0 : my + 1;
          end
`endif
        end
        default: begin
          if (d >= 128) begin
            mbusy = 1;
            for (int i = 0; i < 19200; i++) exp_q.push_back('{addr: i, data: d % 8});
          end
        end
      endcase
    end
    bus(1'b0, 2'(a), 8'(d), hold, dummy);
  endtask

  task automatic rd_chk(input int a, input string nm);
    logic [7:0] v;
    int exp;
    case (a)
      0: exp = mx;
      1: exp = my;
      2: exp = mcol;
      default: exp = mbusy ? 128 : 0;
    endcase
    bus(1'b1, 2'(a), 8'($urandom), 5, v);
    chk(nm, int'(v), exp);
  endtask

  task automatic run_fill(input int d);
    int b0, w0, i;
    b0 = busy_cnt; w0 = we_busy_cnt;
    wr(3, d, 5);
    chk("fill_busy_high", int'(BUSY), 1);
    wr(2, 7, 5);                // dropped during fill
    wr(0, 77, 5);               // dropped during fill
    rd_chk(3, "fill_reg3_read");
    for (i = 0; i < 25000 && BUSY; i++) @(negedge CLK);
    chk("fill_terminates", int'(BUSY), 0);
    mbusy = 0;
    chk("fill_we_busy_cycles", we_busy_cnt - w0, 19200);
    chk("fill_busy_cycles", busy_cnt - b0, 19200);
    chk("fill_queue_drained", exp_q.size(), 0);
    @(negedge CLK);
    chk("fill_we_low_after", int'(FB_WE), 0);
  endtask

  initial begin
    logic [7:0] v;
    int found;

    // Reset
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("rst_fb_we", int'(FB_WE), 0);
    chk("rst_fb_addr", int'(FB_ADDR), 0);
    chk("rst_busy", int'(BUSY), 0);
    chk("rst_dout", int'(DOUT), 0);
    RST = 1'b0;
    repeat (2) @(negedge CLK);
    rd_chk(0, "rst_reg0");
    rd_chk(1, "rst_reg1");

    // Directed pixel write
    wr(0, 10, 5); wr(1, 20, 5); wr(2, 8'h05, 5);
    rd_chk(0, "pix_reg0");
    rd_chk(1, "pix_reg1");
    rd_chk(2, "pix_lastcol");

    // Corner pixel (wraps when auto-increment is built in)
    wr(0, 159, 5); wr(1, 119, 5); wr(2, 8'h03, 5);
    rd_chk(0, "wrap_reg0");
    rd_chk(1, "wrap_reg1");

    // Clamp and long CE hold
    wr(0, 200, 5); wr(1, 255, 5);
    rd_chk(0, "clamp_reg0");
    rd_chk(1, "clamp_reg1");
    wr(2, 8'h06, 50);
    wr(3, 8'h05, 5);            // bit7 clear: no-op
    rd_chk(3, "cmd_noop_reg3");

    // Full fill with writes/reads during it
    run_fill(8'h82);
    rd_chk(0, "post_fill_reg0");
    rd_chk(2, "post_fill_lastcol");

    // Reset mid-fill
    wr(3, 8'h84, 5);
    found = 0;
    for (int i = 0; i < 10000 && found == 0; i++) begin
      @(negedge CLK);
      if (FB_WE && FB_ADDR == 15'd5000) found = 1;
    end
    chk("midfill_reach_5000", found, 1);
    RST = 1'b1;
    @(posedge CLK);
    exp_q.delete();
    mbusy = 0; mx = 0; my = 0; mcol = 0;
    @(negedge CLK);
    chk("midfill_rst_we", int'(FB_WE), 0);
    chk("midfill_rst_busy", int'(BUSY), 0);
    RST = 1'b0;
    repeat (2) @(negedge CLK);
    wr(0, 3, 5); wr(1, 4, 5); wr(2, 8'h06, 5);
    rd_chk(0, "after_rst_reg0");

    // Randomised register traffic (no fills)
    for (int n = 0; n < 60; n++) begin
      int a, d;
      a = $urandom_range(0, 3);
      if ($urandom_range(0, 1) == 1) begin
        rd_chk(a, "rand_read");
      end else begin
        d = $urandom_range(0, 255);
        if (a == 3) d = d % 128;
        wr(a, d, $urandom_range(5, 12));
      end
    end
    rd_chk(0, "rand_final_reg0");
    rd_chk(1, "rand_final_reg1");

    repeat (10) @(negedge CLK);
    chk("final_queue_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
